// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and memory write port of the instruction-memory boot loader.
// A byte transfers on a rising edge where in_valid && in_ready; in_data is don't-care otherwise.
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a framed, XOR-checksummed program image into CPU memory and releases
// the CPU from reset only once the whole image has been written and verified.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_boot_loader_if.slave     bus,
    input  logic                  restart,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        CNT_HI = 3'd0,
        CNT_LO = 3'd1,
        DATA   = 3'd2,
        CHECK  = 3'd3,
        RUN    = 3'd4,
        ERROR  = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        armed;
    logic [7:0]  count_hi;
    logic [15:0] words_total;
    logic [1:0]  byte_idx;
    logic [23:0] asm_q;
    logic [7:0]  csum;

    logic        rdy;
    logic        accept;
    logic [15:0] cnt_full;
    logic        cnt_too_big;
    logic        word_done;
    logic        last_word;
    logic        restart_clear;

    // armed keeps in_ready low until the first edge after reset release
    assign rdy          = armed && (state == CNT_HI || state == CNT_LO ||
                                    state == DATA   || state == CHECK);
    assign bus.in_ready = rdy;
    assign accept       = bus.in_valid && rdy;
    assign cnt_full     = {count_hi, bus.in_data};
    assign cnt_too_big  = 32'(cnt_full) > 32'(MAX_WORDS);
    assign word_done    = accept && (state == DATA) && (byte_idx == 2'd3);
    // The previous word's write has always retired before the next 4th byte,
    // so words_loaded counts every word assembled before this one.
    assign last_word    = (16'(words_loaded) + 16'd1) == words_total;
    assign restart_clear = restart && (state == RUN || state == ERROR);
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= CNT_HI;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cpu_reset  = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (state)
            CNT_HI: if (accept) state_nxt = CNT_LO;
            CNT_LO: begin
                if (accept) begin
                    if (cnt_too_big)        state_nxt = ERROR;
                    else if (cnt_full == 0) state_nxt = CHECK;
                    else                    state_nxt = DATA;
                end
            end
            DATA:   if (word_done && last_word) state_nxt = CHECK;
            CHECK:  if (accept) state_nxt = (bus.in_data == csum) ? RUN : ERROR;
            RUN: begin
                cpu_reset = 1'b0;
                load_done = 1'b1;
                if (restart) state_nxt = CNT_HI;
            end
            ERROR: begin
                load_error = 1'b1;
                if (restart) state_nxt = CNT_HI;
            end
            default: state_nxt = CNT_HI;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed         <= 1'b0;
            count_hi      <= 8'd0;
            words_total   <= 16'd0;
            byte_idx      <= 2'd0;
            asm_q         <= 24'd0;
            csum          <= 8'd0;
            words_loaded  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= ADDR_WIDTH'(BASE_ADDR);
            bus.mem_wdata <= 32'd0;
        end else begin
            armed      <= 1'b1;
            bus.mem_we <= word_done;
            if (accept && state != CHECK) csum <= csum ^ bus.in_data;
            if (accept) begin
                case (state)
                    CNT_HI: count_hi <= bus.in_data;
                    CNT_LO: begin
                        words_total <= cnt_full;
                        byte_idx    <= 2'd0;
                    end
                    DATA: begin
                        asm_q    <= {asm_q[15:0], bus.in_data};
                        byte_idx <= byte_idx + 2'd1;
                    end
                    default: ;
                endcase
            end
            if (word_done) begin
                bus.mem_addr  <= ADDR_WIDTH'(BASE_ADDR) + words_loaded[ADDR_WIDTH-1:0];
                bus.mem_wdata <= {asm_q, bus.in_data};
                words_loaded  <= words_loaded + 1'b1;
            end
            if (restart_clear) begin
                words_loaded <= '0;
                csum         <= 8'd0;
                byte_idx     <= 2'd0;
            end
        end
    end

endmodule
